nim_turn_ctrl: RTL
==================

NIM_TURN_CTRL -- requirements
Module: nim_turn_ctrl

Interface
REQ-001 Parameters: R1_INIT, default 1, initial stones in row 1.
REQ-002 Parameters: R2_INIT, default 3; R3_INIT, default 5; R4_INIT, default 7. Each is the initial stone count for its row; all values are in the range 0..7.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rowSel1..rowSel4  in  1 each  debounced row-select button levels; each rising edge removes one stone.
REQ-006 chPlayer  in  1  debounced end-turn button level.
REQ-007 newGame  in  1  debounced new-game button level.
REQ-008 row1_cnt..row4_cnt  out  3 each  current stones per row, for the display driver.
REQ-009 player  out  1  player to move; 0 = left, 1 = right.
REQ-010 locked_row  out  3  0 = no row taken this turn; 1..4 = row locked for this turn.
REQ-011 game_over  out  1  high while in state OVER.
REQ-012 inc_left, inc_right  out  1 each  one-cycle win pulses to the left and right scoreboards.
REQ-013 illegal  out  1  one-cycle pulse when an input event is rejected.

Function
REQ-014 Each button input shall have a prev register; event = level & ~prev, evaluated every cycle.
REQ-015 Events shall take effect on the same clock edge at which the level is first sampled high; outputs are registered, so latency is 1 edge.
REQ-016 The FSM shall have three states: PLAY (no stone taken this turn), TAKING (row locked), OVER.
REQ-017 Priority shall be newGame > row events > chPlayer.
REQ-018 newGame in any state shall reload all rows to their INIT values, set locked_row=0, set player to the loser of the last game (or keep player if not in OVER), and enter PLAY.
REQ-019 In PLAY, a single row event on a non-empty row k shall decrement row k, set locked_row=k, and enter TAKING.
REQ-020 In TAKING, a row event on locked_row (non-empty) shall decrement that row and stay in TAKING.
REQ-021 A row event on another row, or on an empty row, shall leave state and counts unchanged and pulse illegal.
REQ-022 More than one row event in the same cycle shall be ignored entirely and pulse illegal.
REQ-023 chPlayer in TAKING shall toggle player, set locked_row=0, and enter PLAY.
REQ-024 chPlayer in PLAY shall be rejected with an illegal pulse (at least one stone must be taken per turn).
REQ-025 chPlayer in the same cycle as an accepted row event shall be ignored, with no illegal pulse.
REQ-026 A decrement that makes all four rows 0 shall enter OVER on that edge, and the player who took the last stone wins (normal play).
REQ-027 On entering OVER, the FSM shall pulse inc_left if player=0, or inc_right if player=1, for exactly one cycle.
REQ-028 On entering OVER, player shall toggle to the loser.
REQ-029 In OVER, row and chPlayer events shall be ignored with no illegal pulse; game_over=1 until newGame.
REQ-030 Counts shall never wrap below 0; all count arithmetic is 3-bit unsigned.
REQ-031 If all INIT values are 0, reset and newGame shall enter OVER directly, with no win pulse.

Reset
REQ-032 On reset: rowN_cnt=RN_INIT, player=0, locked_row=0, state PLAY, game_over=0, and inc_left, inc_right and illegal all 0.
REQ-033 All prev registers shall load 1 on reset, so a button held through reset generates no event until it is released and pressed again.
REQ-034 reset shall override all other inputs in the same cycle; a reset asserted mid-turn discards the turn.

Verification
REQ-035 Scenario: reset, then press rowSel4 three times -> row4_cnt 7,6,5,4, locked_row=4, state TAKING, player=0.
REQ-036 Scenario: in TAKING with row 4 locked, press rowSel2 -> illegal pulse, row2_cnt stays 3; press chPlayer -> player=1, locked_row=0.
REQ-037 Scenario: in PLAY, press chPlayer -> illegal pulse, player unchanged; press rowSel1 and rowSel3 in the same cycle -> illegal pulse, counts unchanged.
REQ-038 Scenario: drive counts to 0,0,0,1 with player=1 in PLAY, press rowSel4 -> inc_right high for 1 cycle, game_over=1, player=0; further rowSel and chPlayer presses -> no change and no illegal pulse.
REQ-039 Scenario: in OVER, press newGame -> counts 1,3,5,7, game_over=0, state PLAY, player=0.
REQ-040 Scenario: hold rowSel1 high through reset release -> no decrement; release and press again -> row1_cnt goes 1 to 0; assert reset mid-turn -> all REQ-032 reset values restored on the next edge.

Source files
------------

// File: rtl/nim_turn_ctrl.sv
// Four-row Nim turn controller: button edge detection, per-turn row lock,
// normal-play win detection and scoreboard pulses.
module nim_turn_ctrl #(
  parameter int R1_INIT = 1,
  parameter int R2_INIT = 3,
  parameter int R3_INIT = 5,
  parameter int R4_INIT = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rowSel1,
  input  logic       rowSel2,
  input  logic       rowSel3,
  input  logic       rowSel4,
  input  logic       chPlayer,
  input  logic       newGame,
  output logic [2:0] row1_cnt,
  output logic [2:0] row2_cnt,
  output logic [2:0] row3_cnt,
  output logic [2:0] row4_cnt,
  output logic       player,
  output logic [2:0] locked_row,
  output logic       game_over,
  output logic       inc_left,
  output logic       inc_right,
  output logic       illegal
);

  typedef enum logic [1:0] {PLAY, TAKING, OVER} state_t;

  localparam logic [3:0][2:0] INIT = {3'(R4_INIT), 3'(R3_INIT), 3'(R2_INIT), 3'(R1_INIT)};
  localparam logic ALL_ZERO = (INIT == '0);
  // An all-empty board has no legal move, so the game starts already over.
  localparam state_t START = ALL_ZERO ? OVER : PLAY;

  state_t          state_q;
  logic [3:0][2:0] cnt_q;
  logic [2:0]      locked_q;
  logic            player_q, inc_left_q, inc_right_q, illegal_q;
  logic [3:0]      row_prev_q;
  logic            ch_prev_q, ng_prev_q;

  logic [3:0]      row_lv, row_ev;
  logic            ch_ev, ng_ev;
  logic [1:0]      idx;
  logic            single_ev, row_ok;
  logic [3:0][2:0] cnt_d;

  assign row_lv = {rowSel4, rowSel3, rowSel2, rowSel1};
  assign row_ev = row_lv & ~row_prev_q;
  assign ch_ev  = chPlayer & ~ch_prev_q;
  assign ng_ev  = newGame & ~ng_prev_q;

  always_comb begin
    idx = 2'd0;
    for (int k = 0; k < 4; k++)
      if (row_ev[k]) idx = 2'(k);
  end

  assign single_ev = $onehot(row_ev);
  // In TAKING only the locked row may be touched; PLAY accepts any non-empty row.
  assign row_ok = single_ev && (cnt_q[idx] != 3'd0) &&
                  ((state_q == PLAY) || (locked_q == {1'b0, idx} + 3'd1));

  always_comb begin
    cnt_d = cnt_q;
    cnt_d[idx] = cnt_q[idx] - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= START;
      cnt_q       <= INIT;
      locked_q    <= 3'd0;
      player_q    <= 1'b0;
      inc_left_q  <= 1'b0;
      inc_right_q <= 1'b0;
      illegal_q   <= 1'b0;
      row_prev_q  <= 4'hf;
      ch_prev_q   <= 1'b1;
      ng_prev_q   <= 1'b1;
    end else begin
      row_prev_q  <= row_lv;
      ch_prev_q   <= chPlayer;
      ng_prev_q   <= newGame;
      inc_left_q  <= 1'b0;
      inc_right_q <= 1'b0;
      illegal_q   <= 1'b0;
      if (ng_ev) begin
        // Player already holds the loser after a finished game, so it is kept.
        state_q  <= START;
        cnt_q    <= INIT;
        locked_q <= 3'd0;
      end else if (state_q != OVER) begin
        if (row_ev != 4'd0) begin
          if (row_ok) begin
            cnt_q <= cnt_d;
            if (cnt_d == '0) begin
              state_q     <= OVER;
              locked_q    <= 3'd0;
              inc_left_q  <= ~player_q;
              inc_right_q <= player_q;
              player_q    <= ~player_q;
            end else begin
              state_q  <= TAKING;
              locked_q <= {1'b0, idx} + 3'd1;
            end
          end else begin
            illegal_q <= 1'b1;
          end
        end else if (ch_ev) begin
          if (state_q == TAKING) begin
            state_q  <= PLAY;
            locked_q <= 3'd0;
            player_q <= ~player_q;
          end else begin
            illegal_q <= 1'b1;
          end
        end
      end
    end
  end

  assign row1_cnt   = cnt_q[0];
  assign row2_cnt   = cnt_q[1];
  assign row3_cnt   = cnt_q[2];
  assign row4_cnt   = cnt_q[3];
  assign player     = player_q;
  assign locked_row = locked_q;
  assign game_over  = (state_q == OVER);
  assign inc_left   = inc_left_q;
  assign inc_right  = inc_right_q;
  assign illegal    = illegal_q;

endmodule
